// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU multiply path.
// Defining MANT_MUL_RADIX4_EN selects the 2-bit-per-iteration significand multiplier.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_NORM,
    ST_DONE
  } mul_state_e;

  localparam int FP_BIAS = 127;
  localparam int MANT_W  = 24;
  localparam int PROD_W  = 48;
  localparam int EXP_W   = 10;

`ifdef MANT_MUL_RADIX4_EN
  localparam int MUL_ITERS = 12;
  localparam int STEP_BITS = 2;
`else
  localparam int MUL_ITERS = 24;
  localparam int STEP_BITS = 1;
`endif

  localparam int CNT_W = $clog2(MUL_ITERS);

  // Significand with the hidden bit restored; exponent-0 inputs are flushed elsewhere.
  function automatic logic [MANT_W-1:0] sig_of(input logic [31:0] f);
    return {1'b1, f[22:0]};
  endfunction

  function automatic logic [EXP_W-1:0] exp_of(input logic [31:0] f);
    return {{(EXP_W-8){1'b0}}, f[30:23]};
  endfunction

endpackage

// File: rtl/mul_seq_step.sv
// One shift-add iteration of the significand multiplier.
// MANT_MUL_RADIX4_EN retires two multiplier bits using a precomputed 3x multiplicand.
module mul_seq_step
  import fpu_pkg::*;
(
  input  logic [PROD_W-1:0]    acc,
  input  logic [PROD_W-1:0]    mcand,
`ifdef MANT_MUL_RADIX4_EN
  input  logic [PROD_W-1:0]    mcand3,
`endif
  input  logic [STEP_BITS-1:0] mbits,
  output logic [PROD_W-1:0]    acc_next
);

  logic [PROD_W-1:0] pp;

  always_comb begin
    pp = '0;
`ifdef MANT_MUL_RADIX4_EN
    case (mbits)
      2'd1:    pp = mcand;
      2'd2:    pp = mcand << 1;
      2'd3:    pp = mcand3;
      default: pp = '0;
    endcase
`else
    if (mbits[0]) pp = mcand;
`endif
  end

  assign acc_next = acc + pp;

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential significand multiplier: sign, biased exponent sum, shift-add product, 1-bit normalise.
// Build option MANT_MUL_RADIX4_EN halves the iteration count; results are identical either way.
module mant_mul_seq
  import fpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [31:0]       A,
  input  logic [31:0]       B,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              S_G,
  output logic [PROD_W-1:0] M_OUT,
  output logic [EXP_W-1:0]  E_OUT,
  output logic              ZERO
);

  mul_state_e        state_q, state_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [PROD_W-1:0] m_out_q, m_out_d;
  logic [EXP_W-1:0]  e_out_q, e_out_d;
  logic              s_g_q, s_g_d;
  logic              zero_q, zero_d;
  logic [PROD_W-1:0] acc_step;
  logic              flush;
`ifdef MANT_MUL_RADIX4_EN
  logic [PROD_W-1:0] mcand3_q, mcand3_d;
`endif

  assign flush = (A[30:23] == 8'd0) || (B[30:23] == 8'd0);

  mul_seq_step u_step (
    .acc      (acc_q),
    .mcand    (mcand_q),
`ifdef MANT_MUL_RADIX4_EN
    .mcand3   (mcand3_q),
`endif
    .mbits    (mplier_q[STEP_BITS-1:0]),
    .acc_next (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    m_out_d  = m_out_q;
    e_out_d  = e_out_q;
    s_g_d    = s_g_q;
    zero_d   = zero_q;
`ifdef MANT_MUL_RADIX4_EN
    mcand3_d = mcand3_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = {{(PROD_W-MANT_W){1'b0}}, sig_of(A)};
          mplier_d = sig_of(B);
          s_g_d    = A[31] ^ B[31];
          exp_d    = exp_of(A) + exp_of(B) - EXP_W'(FP_BIAS);
          zero_d   = flush;
`ifdef MANT_MUL_RADIX4_EN
          mcand3_d = {{(PROD_W-MANT_W){1'b0}}, sig_of(A)}
                   + {{(PROD_W-MANT_W-1){1'b0}}, sig_of(A), 1'b0};
`endif
          state_d  = flush ? ST_NORM : ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> STEP_BITS;
        mcand_d  = mcand_q << STEP_BITS;
`ifdef MANT_MUL_RADIX4_EN
        mcand3_d = mcand3_q << STEP_BITS;
`endif
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_ITERS - 1)) state_d = ST_NORM;
      end
      ST_NORM: begin
        // Product of two [1,2) significands lies in [1,4): at most one left shift.
        if (zero_q) begin
          m_out_d = '0;
          e_out_d = '0;
        end else if (acc_q[PROD_W-1]) begin
          m_out_d = acc_q;
          e_out_d = exp_q + EXP_W'(1);
        end else begin
          m_out_d = acc_q << 1;
          e_out_d = exp_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      m_out_q  <= '0;
      e_out_q  <= '0;
      s_g_q    <= 1'b0;
      zero_q   <= 1'b0;
`ifdef MANT_MUL_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      m_out_q  <= m_out_d;
      e_out_q  <= e_out_d;
      s_g_q    <= s_g_d;
      zero_q   <= zero_d;
`ifdef MANT_MUL_RADIX4_EN
      mcand3_q <= mcand3_d;
`endif
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_VALID = (state_q == ST_DONE);
  assign S_G       = s_g_q;
  assign M_OUT     = m_out_q;
  assign E_OUT     = e_out_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_mant_mul_seq.sv
// Self-checking bench for mant_mul_seq: directed and random operands against an arithmetic model.
module tb_mant_mul_seq;

`ifdef MANT_MUL_RADIX4_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 25;
`endif

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] A;
  logic [31:0] B;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        S_G;
  logic [47:0] M_OUT;
  logic [9:0]  E_OUT;
  logic        ZERO;

  int tests = 0;
  int fails = 0;

  mant_mul_seq dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .S_G       (S_G),
    .M_OUT     (M_OUT),
    .E_OUT     (E_OUT),
    .ZERO      (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: real multiplication of the restored significands, then normalise.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [47:0] m, output logic [9:0] e,
                       output logic s, output logic z);
    logic [47:0] p;
    int ex;
    s = a[31] ^ b[31];
    if (a[30:23] == 0 || b[30:23] == 0) begin
      m = '0;
      e = '0;
      z = 1'b1;
    end else begin
      p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      ex = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
        m = p;
        ex = ex + 1;
      end else begin
        m = p << 1;
      end
      e = ex[9:0];
      z = 1'b0;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit consume);
    logic [47:0] em;
    logic [9:0]  ee;
    logic        es, ez;
    int          cyc;
    model(a, b, em, ee, es, ez);
    @(negedge CLK);
    chk({tag, ":in_ready"}, 64'(IN_READY), 64'd1);
    A = a;
    B = b;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    cyc = 0;
    while (!OUT_VALID && cyc < 200) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    chk({tag, ":latency"}, 64'(cyc), 64'(ez ? 1 : LAT));
    chk({tag, ":m_out"}, 64'(M_OUT), 64'(em));
    chk({tag, ":e_out"}, 64'(E_OUT), 64'(ee));
    chk({tag, ":s_g"}, 64'(S_G), 64'(es));
    chk({tag, ":zero"}, 64'(ZERO), 64'(ez));
    if (consume) begin
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;
      chk({tag, ":out_valid_drop"}, 64'(OUT_VALID), 64'd0);
      chk({tag, ":in_ready_back"}, 64'(IN_READY), 64'd1);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [47:0] em;
    logic [9:0]  ee;
    logic        es, ez;
    bit          rose;

    RST_N = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset:in_ready", 64'(IN_READY), 64'd1);
    chk("reset:out_valid", 64'(OUT_VALID), 64'd0);
    chk("reset:m_out", 64'(M_OUT), 64'd0);
    chk("reset:e_out", 64'(E_OUT), 64'd0);
    chk("reset:s_g", 64'(S_G), 64'd0);
    chk("reset:zero", 64'(ZERO), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed cases with literal expectations.
    run_op(32'h3F800000, 32'h3F800000, "one_x_one", 1'b1);
    chk("one_x_one:m_lit", 64'(M_OUT), 64'h800000000000);
    chk("one_x_one:e_lit", 64'(E_OUT), 64'd127);
    run_op(32'h3FC00000, 32'h3FC00000, "1p5_sq", 1'b1);
    chk("1p5_sq:m_lit", 64'(M_OUT), 64'h900000000000);
    chk("1p5_sq:e_lit", 64'(E_OUT), 64'd128);
    run_op(32'hC0000000, 32'h40400000, "neg2_x_3", 1'b1);
    chk("neg2_x_3:m_lit", 64'(M_OUT), 64'hC00000000000);
    chk("neg2_x_3:e_lit", 64'(E_OUT), 64'd129);
    chk("neg2_x_3:s_lit", 64'(S_G), 64'd1);
    run_op(32'h00000000, 32'h40400000, "flush", 1'b1);
    chk("flush:zero_lit", 64'(ZERO), 64'd1);
    run_op(32'h7F800000, 32'hFFFFFFFF, "exp255", 1'b1);

    // Hold in DONE with OUT_READY low; IN_VALID pulses must be ignored.
    run_op(32'hBFC00000, 32'h40A00000, "hold", 1'b0);
    model(32'hBFC00000, 32'h40A00000, em, ee, es, ez);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      A = $urandom;
      B = $urandom;
      IN_VALID = i[0];
      @(posedge CLK);
      #1;
      chk("hold:in_ready", 64'(IN_READY), 64'd0);
      chk("hold:out_valid", 64'(OUT_VALID), 64'd1);
      chk("hold:m_out", 64'(M_OUT), 64'(em));
      chk("hold:e_out", 64'(E_OUT), 64'(ee));
      chk("hold:s_g", 64'(S_G), 64'(es));
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    chk("hold:release_idle", 64'(IN_READY), 64'd1);
    chk("hold:release_valid", 64'(OUT_VALID), 64'd0);

    // Random operands, occasional zero exponent.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra[30:23] = 8'd0;
      if ($urandom_range(0, 7) == 0) rb[30:23] = 8'd0;
      run_op(ra, rb, $sformatf("rand%0d", i), 1'b1);
    end

    // Abort mid-computation with an asynchronous reset.
    @(negedge CLK);
    A = 32'h3FC00000;
    B = 32'h3FC00000;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("abort:in_ready", 64'(IN_READY), 64'd1);
    chk("abort:out_valid", 64'(OUT_VALID), 64'd0);
    chk("abort:m_out", 64'(M_OUT), 64'd0);
    chk("abort:e_out", 64'(E_OUT), 64'd0);
    chk("abort:s_g", 64'(S_G), 64'd0);
    chk("abort:zero", 64'(ZERO), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      if (OUT_VALID) rose = 1'b1;
    end
    chk("abort:no_valid", 64'(rose), 64'd0);
    run_op(32'h3F800000, 32'h3F800000, "after_abort", 1'b1);
    chk("after_abort:m_lit", 64'(M_OUT), 64'h800000000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
